// File: rtl/sw_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : sw_pkg
// Desc    : Constants and types shared by the Smith-Waterman core and its feeder.
// Rev     : 1.0
// ------------------------------------------------------------------
package sw_pkg;

    localparam int REF_LEN         = 64;
    localparam int QUERY_LEN       = 48;
    localparam int WIDTH_SCORE     = 8;
    localparam int WIDTH_POS_REF   = 7;
    localparam int WIDTH_POS_QUERY = 6;

    typedef logic [1:0] base_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/sw_job_feeder_if.sv
`default_nettype none
// ------------------------------------------------------------------
// Interface : sw_job_feeder_if
// Desc      : Core base stream / finish capture plus host result handshake.
// Rev       : 1.0
// ------------------------------------------------------------------
interface sw_job_feeder_if;
    import sw_pkg::*;

    logic                       sw_valid;
    base_t                      sw_data_ref;
    base_t                      sw_data_query;
    logic                       sw_finish;
    logic [WIDTH_SCORE-1:0]     sw_max;
    logic [WIDTH_POS_REF-1:0]   sw_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] sw_pos_query;

    logic                       res_valid;
    logic                       res_ready;
    logic [WIDTH_SCORE-1:0]     res_max;
    logic [WIDTH_POS_REF-1:0]   res_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] res_pos_query;
    logic                       res_timeout;

    modport master (
        output sw_valid, sw_data_ref, sw_data_query,
        input  sw_finish, sw_max, sw_pos_ref, sw_pos_query,
        output res_valid, res_max, res_pos_ref, res_pos_query, res_timeout,
        input  res_ready
    );

    modport slave (
        input  sw_valid, sw_data_ref, sw_data_query,
        output sw_finish, sw_max, sw_pos_ref, sw_pos_query,
        input  res_valid, res_max, res_pos_ref, res_pos_query, res_timeout,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/sw_base_mem.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : sw_base_mem
// Desc   : 2-bit base register file, one write port, one combinational read.
// Rev    : 1.0
// ------------------------------------------------------------------
module sw_base_mem
    import sw_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic          wr_en,
    input  wire logic [AW-1:0] wr_addr,
    input  wire logic [1:0]    wr_data,
    input  wire logic [AW-1:0] rd_addr,
    output base_t              rd_data
);

    base_t r_mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/sw_job_feeder.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : sw_job_feeder
// Desc   : Buffers host bases, streams them into the Smith-Waterman core,
//          captures the finish result and hands it back on valid/ready.
// Rev    : 1.0
// ------------------------------------------------------------------
module sw_job_feeder
    import sw_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       wr_en,
    input  wire logic       wr_sel,
    input  wire logic [5:0] wr_addr,
    input  wire logic [1:0] wr_data,
    input  wire logic       start,
    output logic            ready,
    output logic            lock_err,
    sw_job_feeder_if.master bus
);

    localparam int c_IW  = $clog2(REF_LEN);
    localparam int c_QAW = $clog2(QUERY_LEN);
    localparam int c_WW  = $clog2(TIMEOUT + 1);
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(REF_LEN - 1);
    localparam logic [c_WW-1:0] c_WD_LAST  = c_WW'(TIMEOUT - 1);

    feeder_state_e r_state, w_state_nxt;
    logic [c_IW-1:0] r_idx;
    logic [c_WW-1:0] r_wdog;

    logic  r_sw_valid, r_lock_err, r_res_timeout;
    base_t r_sw_ref, r_sw_qry;
    logic [WIDTH_SCORE-1:0]     r_res_max;
    logic [WIDTH_POS_REF-1:0]   r_res_pos_ref;
    logic [WIDTH_POS_QUERY-1:0] r_res_pos_query;

    logic  w_addr_ok, w_wr_ok, w_wr_drop, w_byp;
    logic  w_valid_nxt;
    base_t w_ref_mem, w_qry_mem, w_ref_rd, w_qry_rd, w_ref_nxt, w_qry_nxt;
    logic [c_IW-1:0] w_rd_idx;

    assign w_addr_ok = wr_sel ? (int'(wr_addr) < QUERY_LEN) : (int'(wr_addr) < REF_LEN);
    assign w_wr_ok   = wr_en && (r_state == ST_IDLE) && w_addr_ok;
    assign w_wr_drop = wr_en && !w_wr_ok;

    // The index presented next cycle; the first one (0) is read while still in IDLE.
    assign w_rd_idx = (r_state == ST_STREAM) ? r_idx + c_IW'(1) : '0;

    sw_base_mem #(.DEPTH(REF_LEN), .AW(c_IW)) u_ref_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_ok && !wr_sel),
        .wr_addr (wr_addr[c_IW-1:0]),
        .wr_data (wr_data),
        .rd_addr (w_rd_idx),
        .rd_data (w_ref_mem)
    );

    sw_base_mem #(.DEPTH(QUERY_LEN), .AW(c_QAW)) u_qry_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_ok && wr_sel),
        .wr_addr (wr_addr[c_QAW-1:0]),
        .wr_data (wr_data),
        .rd_addr (w_rd_idx[c_QAW-1:0]),
        .rd_data (w_qry_mem)
    );

    // A write to index 0 landing on the start edge must reach the first streamed pair.
    assign w_byp    = w_wr_ok && (wr_addr == '0);
    assign w_ref_rd = (w_byp && !wr_sel) ? wr_data : w_ref_mem;
    assign w_qry_rd = (int'(w_rd_idx) >= QUERY_LEN) ? 2'b00 :
                      (w_byp && wr_sel) ? wr_data : w_qry_mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_STREAM;
            ST_STREAM: if (r_idx == c_IDX_LAST) w_state_nxt = ST_WAIT;
            ST_WAIT:   if (bus.sw_finish || (r_wdog == c_WD_LAST)) w_state_nxt = ST_RESULT;
            ST_RESULT: if (bus.res_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_valid_nxt = 1'b0;
        w_ref_nxt   = '0;
        w_qry_nxt   = '0;
        if (w_state_nxt == ST_STREAM) begin
            w_valid_nxt = 1'b1;
            w_ref_nxt   = w_ref_rd;
            w_qry_nxt   = w_qry_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx           <= '0;
            r_wdog          <= '0;
            r_sw_valid      <= 1'b0;
            r_sw_ref        <= '0;
            r_sw_qry        <= '0;
            r_lock_err      <= 1'b0;
            r_res_timeout   <= 1'b0;
            r_res_max       <= '0;
            r_res_pos_ref   <= '0;
            r_res_pos_query <= '0;
        end else begin
            r_sw_valid <= w_valid_nxt;
            r_sw_ref   <= w_ref_nxt;
            r_sw_qry   <= w_qry_nxt;
            r_lock_err <= w_wr_drop;
            r_idx      <= (r_state == ST_STREAM) ? r_idx + c_IW'(1) : '0;
            r_wdog     <= (r_state == ST_WAIT) ? r_wdog + c_WW'(1) : '0;
            // Core outputs are only meaningful in the finish cycle itself.
            if (r_state == ST_WAIT) begin
                if (bus.sw_finish) begin
                    r_res_max       <= bus.sw_max;
                    r_res_pos_ref   <= bus.sw_pos_ref;
                    r_res_pos_query <= bus.sw_pos_query;
                    r_res_timeout   <= 1'b0;
                end else if (r_wdog == c_WD_LAST) begin
                    r_res_max       <= '0;
                    r_res_pos_ref   <= '0;
                    r_res_pos_query <= '0;
                    r_res_timeout   <= 1'b1;
                end
            end
        end
    end

    assign ready             = (r_state == ST_IDLE);
    assign lock_err          = r_lock_err;
    assign bus.sw_valid      = r_sw_valid;
    assign bus.sw_data_ref   = r_sw_ref;
    assign bus.sw_data_query = r_sw_qry;
    assign bus.res_valid     = (r_state == ST_RESULT);
    assign bus.res_max       = r_res_max;
    assign bus.res_pos_ref   = r_res_pos_ref;
    assign bus.res_pos_query = r_res_pos_query;
    assign bus.res_timeout   = r_res_timeout;

endmodule
`default_nettype wire

// File: doc/sw_job_feeder.md
Name: sw_job_feeder

Overview:
- Host-side driver for the Smith-Waterman scoring core. It is the transmitting end of the core's serial base-stream input and the receiving end of its result outputs.
- Host writes reference and query bases into local buffers, then pulses start. The block streams one base pair per cycle into the core, waits for the core's finish pulse, and captures the score and position.
- The captured result is presented to the host on a valid/ready handshake.
- A watchdog flags a core that never finishes.

Parameters:
REF_LEN, 64, number of reference bases per job (core buffer depth)
QUERY_LEN, 48, number of query bases per job; must be <= REF_LEN
WIDTH_SCORE, 8, width of core max score
WIDTH_POS_REF, 7, width of core reference position
WIDTH_POS_QUERY, 6, width of core query position
TIMEOUT, 255, maximum WAIT cycles before the job is declared failed

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wr_en  in  1  host buffer write strobe
wr_sel  in  1  0 = reference buffer, 1 = query buffer
wr_addr  in  6  base index (reference uses 0..REF_LEN-1, query uses 0..QUERY_LEN-1)
wr_data  in  2  base code
start  in  1  job request; accepted only when ready=1
ready  out  1  1 in IDLE only
lock_err  out  1  one-cycle pulse when a write is dropped (busy or out-of-range address)
sw_valid  out  1  core valid
sw_data_ref  out  2  reference base to core
sw_data_query  out  2  query base to core
sw_finish  in  1  core finish pulse
sw_max  in  WIDTH_SCORE  core max score
sw_pos_ref  in  WIDTH_POS_REF  core ref position
sw_pos_query  in  WIDTH_POS_QUERY  core query position
res_valid  out  1  result available
res_ready  in  1  host accepts result
res_max  out  WIDTH_SCORE  captured score
res_pos_ref  out  WIDTH_POS_REF  captured ref position
res_pos_query  out  WIDTH_POS_QUERY  captured query position
res_timeout  out  1  1 = job hit the watchdog; result fields are 0

Behaviour:
- Reset values:
  - state IDLE; all outputs 0 except ready=1.
  - Index counter 0, watchdog counter 0.
  - Buffers cleared to 2'b00.
- States: IDLE, STREAM, WAIT, RESULT.
- IDLE:
  - Writes are accepted; wr_addr beyond the selected buffer depth is dropped and pulses lock_err.
  - start=1 at cycle t moves to STREAM at t+1; idx=0.
  - A write and start in the same cycle: the write lands first and the streamed data includes it.
- STREAM, cycles t+1 .. t+REF_LEN:
  - sw_valid=1; sw_data_ref=ref[idx].
  - sw_data_query=query[idx] if idx<QUERY_LEN, else 2'b00.
  - idx increments each cycle. On idx==REF_LEN-1 go to WAIT.
  - All outputs are registered, so data for index k appears exactly k+1 cycles after the start cycle.
- WAIT:
  - sw_valid=0 and data outputs 0. The core re-arms only with valid low, so sw_valid is never held high outside STREAM.
  - Watchdog increments each cycle.
  - sw_finish=1: capture sw_max, sw_pos_ref, sw_pos_query that same cycle (core outputs are valid only during the finish cycle). Go to RESULT with res_timeout=0.
  - Watchdog reaches TIMEOUT with no finish: go to RESULT with res_timeout=1 and result fields 0.
  - Finish and timeout in the same cycle: finish wins.
- RESULT:
  - res_valid=1; fields stay stable until res_valid & res_ready. Then go to IDLE and clear res_valid the next cycle.
  - A late sw_finish while in RESULT is ignored.
- sw_finish in IDLE or STREAM is ignored.
- Writes in STREAM/WAIT/RESULT are dropped and pulse lock_err; buffers keep their contents across jobs.
- start outside IDLE is ignored (no queueing).
- Reset mid-job: immediate return to reset values. sw_valid drops asynchronously.

Decomposition:
- Shared package sw_pkg holds:
  - REF_LEN, QUERY_LEN and the three width constants, shared with the core.
  - A 2-bit base-code typedef.
  - The feeder state enum.
- Sub-module sw_base_mem: parameterised 2-bit-wide register file with 1 write port and 1 combinational read port. Instantiated twice, once for reference and once for query.

Test Plan:
- Basic job:
  - Stimulus: load ref[i]=i%4 and query[i]=3-(i%4); start at cycle 10. Core stub pulses finish 120 cycles after the first valid with max=0x2A, pos_ref=0x3F, pos_query=0x2F.
  - Required: sw_valid high cycles 11..74; ref index 5 appears at cycle 16 as 2'b01; sw_data_query=0 for indices 48..63; res_valid=1 with 0x2A/0x3F/0x2F and res_timeout=0.
- Backpressure:
  - Stimulus: hold res_ready=0 for 20 cycles after res_valid.
  - Required: result fields stable for all 20 cycles; ready=0 throughout; ready=1 the cycle after the handshake.
- Watchdog:
  - Stimulus: core stub never finishes.
  - Required: res_valid rises TIMEOUT cycles after WAIT entry; res_timeout=1; fields 0.
- Locking and ignored inputs:
  - Stimulus: wr_en during STREAM; start during WAIT; stray sw_finish during STREAM.
  - Required: lock_err pulses once per dropped write; buffer contents unchanged; no second job; stray finish ignored.
- Mid-job reset:
  - Stimulus: reset asserted at stream index 30.
  - Required: sw_valid=0 immediately; ready=1; buffers read 0; a fresh job then completes normally.
- Back-to-back jobs:
  - Stimulus: start asserted in the cycle immediately after the first job's handshake.
  - Required: sw_valid low for at least the WAIT/RESULT span between the two streams; second result correct.
